wm_status_display: RTL and testbench
====================================

# wm_status_display

Status display stage for the washing machine controller. It consumes the controller's mode and unified stage code and drives four active-low seven-segment digits: a two-letter stage mnemonic and the seconds elapsed in the current stage. It also blinks a completion message and flags invalid mode settings. All outputs are registered. It sits directly downstream of the cycle sequencer on the board top level.

## Interface

Parameters:
- `TICK_DIV`, default 27000000: `CLOCK_27` cycles per one-second tick. Legal range is 2 to 2^25.

Ports:
- `CLOCK_27`  in  1  system clock. This is the only clock.
- `RESET`  in  1  reset, asynchronous and active-high.
- `mode`  in  2  controller mode: 0 = wait, 1 = standard, 2 = quick, 3 = invalid.
- `stage`  in  3  unified stage code: 0 idle, 1 fill, 2 agitate, 3 soak, 4 agitate2, 5 drain, 6 spin, 7 done.
- `HEX3`, `HEX2`  out  7 each  mnemonic digits, active-low, bit order {g,f,e,d,c,b,a}.
- `HEX1`, `HEX0`  out  7 each  elapsed-seconds digits (tens, ones), active-low.
- `err`  out  1  high while `mode` is 3.
- `elapsed`  out  8  elapsed seconds as packed BCD {tens,ones}, for debug.

## Operation

Segment codes, active-low:
- blank = 7F, dash = 3F
- digits 0–9 = 40, 79, 24, 30, 19, 12, 02, 78, 00, 10
- letters: F = 0E, L = 47, A = 08, G = 42, S = 12, O = 40, d = 21, r = 2F, P = 0C, E = 06, n = 2B

Input register:
- `mode` and `stage` are registered every cycle into `mode_q` and `stage_q`.
- `stage_prev` holds the previous `stage_q`.
- A stage change is detected when `stage_q != stage_prev`.

Prescaler:
- Counter runs 0..TICK_DIV-1.
- `tick` is a one-cycle pulse when the counter equals TICK_DIV-1; the counter then wraps to 0.
- The counter is forced to 0 on stage change, and while `mode_q` is 0 or 3.

Seconds counter:
- Two BCD digits, 00..99.
- Increments on `tick`. Ones wrap 9→0 and carry into tens.
- Saturates at 99.
- Cleared to 00 on stage change. If a tick and a stage change occur in the same cycle, the clear wins.
- Held at 00 while `mode_q` is 0 or 3.

Blink flag:
- Toggles on each `tick` while `stage_q` is 7.
- Forced to "on" on stage change and whenever `stage_q` is not 7.

Display selection, priority order, top first:
1. `mode_q` = 3: HEX3/HEX2 show E, r. HEX1/HEX0 are blank. `err` = 1.
2. `mode_q` = 0: HEX3/HEX2 show dash, dash. HEX1/HEX0 are blank.
3. `stage_q` = 7: HEX3/HEX2 show E, n when blink is on, blank when blink is off. HEX1/HEX0 are blank.
4. Otherwise HEX3/HEX2 show the stage mnemonic and HEX1/HEX0 show the seconds.
   - Mnemonics: 0 "- -", 1 "FL", 2 "AG", 3 "SO", 4 "A2", 5 "dr", 6 "SP".
   - Seconds: tens shows the digit code, or blank when tens is 0. Ones always shows the digit code.

Other rules:
- `err` = 0 in every case except mode 3.
- `elapsed` always reflects the seconds counter.

## Timing

Reset (asynchronous, immediate):
- HEX3..HEX0 = 7F, `err` = 0, `elapsed` = 00.
- Prescaler = 0, blink = on.
- `mode_q` = 0, `stage_q` = 0, `stage_prev` = 0.
- Releasing `RESET` produces dash, dash on the next clock.

Latency:
- Input change to display update is 2 cycles (input register, then output register).
- Stage change to seconds showing 00 is 2 cycles.
- After a stage change, the first increment appears on the outputs exactly TICK_DIV+2 cycles after the new `stage` value is applied.
- Each later increment follows every TICK_DIV cycles.

Boundary behaviour:
- Changing `mode` without changing `stage` does not clear the count, except that entering mode 0 or 3 clears it and leaving starts again from 00.
- `stage` toggling every cycle keeps the seconds at 00 and blink on.
- `RESET` asserted mid-stage discards all state. There is no resume.

## Test plan

Use TICK_DIV = 4 for all scenarios.

1. **Mid-operation reset.** Assert `RESET` during stage 2 at 05 s → HEX outputs read 7F within the same cycle and `err` = 0; release → HEX3/HEX2 = 3F, 3F after one clock.
2. **Fill counting.** `mode` = 1, `stage` = 1 → HEX3 = 0E, HEX2 = 47, HEX1 = 7F, HEX0 = 40 two cycles later; after 40 further cycles HEX1 = 79, HEX0 = 40 (10 s) and `elapsed` = 0x10.
3. **Stage change.** At 07 s, set `stage` = 2 → HEX3/HEX2 = 08/42 and HEX0 = 40 after 2 cycles; the next increment (01) appears exactly 6 cycles after the change.
4. **Saturation.** Hold `stage` = 3 for 420 cycles → `elapsed` = 0x99, HEX1 = 10, HEX0 = 10, and the value does not change afterwards.
5. **Done blink.** `stage` = 7 → HEX3/HEX2 alternate between 06/2B and 7F/7F every 4 cycles, starting with "on"; HEX1/HEX0 = 7F throughout.
6. **Mode precedence.** `mode` = 3 with `stage` = 4 → HEX3/HEX2 = 06/2F and `err` = 1; then `mode` = 0 → 3F, 3F, 7F, 7F and `err` = 0; then `mode` = 2 → "A2" and seconds 0.

Source files
------------

// File: rtl/wm_status_display.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wm_status_display
//   Four-digit seven-segment status stage: stage mnemonic, elapsed seconds,
//   blinking completion message and invalid-mode error.
//   Revision: 1.0
// ----------------------------------------------------------------------------
module wm_status_display #(
  parameter int TICK_DIV = 27000000
) (
  input  logic       CLOCK_27,
  input  logic       RESET,
  input  logic [1:0] mode,
  input  logic [2:0] stage,
  output logic [6:0] HEX3,
  output logic [6:0] HEX2,
  output logic [6:0] HEX1,
  output logic [6:0] HEX0,
  output logic       err,
  output logic [7:0] elapsed
);

  localparam int            CW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_R     = 7'h2F;
  localparam logic [6:0] SEG_N     = 7'h2B;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_L     = 7'h47;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_G     = 7'h42;
  localparam logic [6:0] SEG_S     = 7'h12;
  localparam logic [6:0] SEG_O     = 7'h40;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_P     = 7'h0C;
  localparam logic [6:0] SEG_TWO   = 7'h24;

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  logic [1:0]    mode_q;
  logic [2:0]    stage_q;
  logic [2:0]    stage_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic          blink_q, blink_d;
  logic [6:0]    hex3_q, hex3_d;
  logic [6:0]    hex2_q, hex2_d;
  logic [6:0]    hex1_q, hex1_d;
  logic [6:0]    hex0_q, hex0_d;
  logic          err_q, err_d;

  logic stage_chg;
  logic hold;
  logic tick;

  assign stage_chg = (stage_q != stage_prev_q);
  assign hold      = (mode_q == 2'd0) || (mode_q == 2'd3);
  assign tick      = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d   = cnt_q + CW'(1);
    tens_d  = tens_q;
    ones_d  = ones_q;
    blink_d = blink_q;
    if (hold || stage_chg || tick) begin
      cnt_d = '0;
    end
    // Clear beats increment; 99 is sticky until the next clear.
    if (hold || stage_chg) begin
      tens_d = 4'd0;
      ones_d = 4'd0;
    end else if (tick && !(tens_q == 4'd9 && ones_q == 4'd9)) begin
      if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
    if (stage_chg || stage_q != 3'd7) begin
      blink_d = 1'b1;
    end else if (tick) begin
      blink_d = ~blink_q;
    end
  end

  // Uses next-state counter/blink so the display shows a new value on the same
  // edge the counter takes it.
  always_comb begin
    hex3_d = SEG_BLANK;
    hex2_d = SEG_BLANK;
    hex1_d = SEG_BLANK;
    hex0_d = SEG_BLANK;
    err_d  = 1'b0;
    if (mode_q == 2'd3) begin
      hex3_d = SEG_E;
      hex2_d = SEG_R;
      err_d  = 1'b1;
    end else if (mode_q == 2'd0) begin
      hex3_d = SEG_DASH;
      hex2_d = SEG_DASH;
    end else if (stage_q == 3'd7) begin
      if (blink_d) begin
        hex3_d = SEG_E;
        hex2_d = SEG_N;
      end
    end else begin
      case (stage_q)
        3'd1:    begin hex3_d = SEG_F; hex2_d = SEG_L;   end
        3'd2:    begin hex3_d = SEG_A; hex2_d = SEG_G;   end
        3'd3:    begin hex3_d = SEG_S; hex2_d = SEG_O;   end
        3'd4:    begin hex3_d = SEG_A; hex2_d = SEG_TWO; end
        3'd5:    begin hex3_d = SEG_D; hex2_d = SEG_R;   end
        3'd6:    begin hex3_d = SEG_S; hex2_d = SEG_P;   end
        default: begin hex3_d = SEG_DASH; hex2_d = SEG_DASH; end
      endcase
      hex1_d = (tens_d == 4'd0) ? SEG_BLANK : digit_seg(tens_d);
      hex0_d = digit_seg(ones_d);
    end
  end

  always_ff @(posedge CLOCK_27 or posedge RESET) begin
    if (RESET) begin
      mode_q       <= 2'd0;
      stage_q      <= 3'd0;
      stage_prev_q <= 3'd0;
      cnt_q        <= '0;
      tens_q       <= 4'd0;
      ones_q       <= 4'd0;
      blink_q      <= 1'b1;
      hex3_q       <= SEG_BLANK;
      hex2_q       <= SEG_BLANK;
      hex1_q       <= SEG_BLANK;
      hex0_q       <= SEG_BLANK;
      err_q        <= 1'b0;
    end else begin
      mode_q       <= mode;
      stage_q      <= stage;
      stage_prev_q <= stage_q;
      cnt_q        <= cnt_d;
      tens_q       <= tens_d;
      ones_q       <= ones_d;
      blink_q      <= blink_d;
      hex3_q       <= hex3_d;
      hex2_q       <= hex2_d;
      hex1_q       <= hex1_d;
      hex0_q       <= hex0_d;
      err_q        <= err_d;
    end
  end

  assign HEX3    = hex3_q;
  assign HEX2    = hex2_q;
  assign HEX1    = hex1_q;
  assign HEX0    = hex0_q;
  assign err     = err_q;
  assign elapsed = {tens_q, ones_q};

endmodule
`default_nettype wire

// File: tb/tb_wm_status_display.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_wm_status_display
//   Scoreboard bench: stimulus pushes expected display words, monitor compares.
//   Revision: 1.0
// ----------------------------------------------------------------------------
module tb_wm_status_display;

  localparam int T = 4;

  logic       CLOCK_27 = 1'b0;
  logic       RESET    = 1'b1;
  logic [1:0] mode     = 2'd0;
  logic [2:0] stage    = 3'd0;
  logic [6:0] HEX3, HEX2, HEX1, HEX0;
  logic       err;
  logic [7:0] elapsed;

  wm_status_display #(.TICK_DIV(T)) dut (
    .CLOCK_27 (CLOCK_27),
    .RESET    (RESET),
    .mode     (mode),
    .stage    (stage),
    .HEX3     (HEX3),
    .HEX2     (HEX2),
    .HEX1     (HEX1),
    .HEX0     (HEX0),
    .err      (err),
    .elapsed  (elapsed)
  );

  always #5 CLOCK_27 = ~CLOCK_27;

  typedef struct packed {
    logic [6:0] e_h3;
    logic [6:0] e_h2;
    logic [6:0] e_h1;
    logic [6:0] e_h0;
    logic       e_err;
    logic [7:0] e_el;
  } exp_t;

  localparam logic [6:0] DIG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                      7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  localparam logic [6:0] MN3 [7]  = '{7'h3F, 7'h0E, 7'h08, 7'h12, 7'h08, 7'h21, 7'h12};
  localparam logic [6:0] MN2 [7]  = '{7'h3F, 7'h47, 7'h42, 7'h40, 7'h24, 7'h2F, 7'h0C};

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Model state: inputs sampled on the latest edge and where the current run began.
  int s_mode  = 0;
  int s_stage = 0;
  int run_a   = 0;
  int run_off = 0;
  int ecount  = 0;

  function automatic bit is_hold(input int m);
    return (m == 0) || (m == 3);
  endfunction

  // n = whole seconds since the run began (unsaturated; parity gives blink phase)
  function automatic exp_t model(input int m, input int st, input int n);
    exp_t r;
    int   sec;
    sec     = (n > 99) ? 99 : n;
    r.e_h3  = 7'h7F;
    r.e_h2  = 7'h7F;
    r.e_h1  = 7'h7F;
    r.e_h0  = 7'h7F;
    r.e_err = 1'b0;
    r.e_el  = 8'h00;
    if (m == 3) begin
      r.e_h3  = 7'h06;
      r.e_h2  = 7'h2F;
      r.e_err = 1'b1;
    end else if (m == 0) begin
      r.e_h3 = 7'h3F;
      r.e_h2 = 7'h3F;
    end else begin
      r.e_el = 8'((sec / 10) * 16 + (sec % 10));
      if (st == 7) begin
        if (n % 2 == 0) begin
          r.e_h3 = 7'h06;
          r.e_h2 = 7'h2B;
        end
      end else begin
        r.e_h3 = MN3[st];
        r.e_h2 = MN2[st];
        r.e_h1 = (sec / 10 == 0) ? 7'h7F : DIG[sec / 10];
        r.e_h0 = DIG[sec % 10];
      end
    end
    return r;
  endfunction

  task automatic step(input int m, input int st);
    int n;
    @(negedge CLOCK_27);
    ecount = ecount + 1;
    n = is_hold(s_mode) ? 0 : (ecount - run_a - run_off) / T;
    exp_q.push_back(model(s_mode, s_stage, n));
    mode  = 2'(m);
    stage = 3'(st);
    if (st != s_stage) begin
      run_a   = ecount;
      run_off = 1;
    end else if (is_hold(m) != is_hold(s_mode)) begin
      run_a   = ecount;
      run_off = 0;
    end
    s_mode  = m;
    s_stage = st;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    compared = compared + 1;
    if (act !== req) begin
      mismatched = mismatched + 1;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic do_reset();
    @(negedge CLOCK_27);
    mode  = 2'd0;
    stage = 3'd0;
    #2 RESET = 1'b1;
    #1;
    chk("reset HEX3", {1'b0, HEX3}, 8'h7F);
    chk("reset HEX2", {1'b0, HEX2}, 8'h7F);
    chk("reset HEX1", {1'b0, HEX1}, 8'h7F);
    chk("reset HEX0", {1'b0, HEX0}, 8'h7F);
    chk("reset err", {7'd0, err}, 8'h00);
    chk("reset elapsed", elapsed, 8'h00);
    @(posedge CLOCK_27);
    #2 RESET = 1'b0;
    s_mode  = 0;
    s_stage = 0;
  endtask

  always @(posedge CLOCK_27) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      compared = compared + 1;
      if ({HEX3, HEX2, HEX1, HEX0, err, elapsed} !== e) begin
        mismatched = mismatched + 1;
        $display("FAIL display @%0t: got %h %h %h %h err=%b el=%h, expected %h %h %h %h err=%b el=%h",
                 $time, HEX3, HEX2, HEX1, HEX0, err, elapsed,
                 e.e_h3, e.e_h2, e.e_h1, e.e_h0, e.e_err, e.e_el);
      end
    end
  end

  initial begin
    do_reset();
    // Fill counting to 10 s, then mid-stage reset in stage 2
    repeat (45) step(1, 1);
    repeat (24) step(1, 2);
    do_reset();
    // Stage change at 07 s
    repeat (31) step(1, 1);
    repeat (12) step(1, 2);
    // Saturation
    repeat (420) step(2, 3);
    // Done blink
    repeat (20) step(1, 7);
    // Mode precedence
    repeat (4) step(3, 4);
    repeat (4) step(0, 4);
    repeat (10) step(2, 4);
    // Stage toggling every cycle
    for (int i = 0; i < 12; i++) step(1, (i % 2 == 0) ? 5 : 6);
    repeat (6) step(1, 6);
    // Random segments
    for (int k = 0; k < 80; k++) begin
      int m, st, len;
      st  = ($urandom % 2 == 0) ? s_stage : int'($urandom_range(0, 7));
      m   = ($urandom % 3 == 0) ? s_mode : int'($urandom_range(0, 3));
      if (st == 7 && s_stage == 7) m = s_mode;
      len = ($urandom % 10 == 0) ? int'($urandom_range(100, 450)) : int'($urandom_range(1, 40));
      for (int j = 0; j < len; j++) step(m, st);
      if (k % 20 == 19) do_reset();
    end
    @(negedge CLOCK_27);
    @(negedge CLOCK_27);
    compared = compared + 1;
    if (exp_q.size() != 0) begin
      mismatched = mismatched + 1;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
